// File: rtl/rdma_hdr_pkg.sv
// ============================================================================
// rdma_hdr_pkg: RDMA header layout, marker and FSM encoding shared by tx/rx. Rev 1.0
// ============================================================================
`default_nettype none

package rdma_hdr_pkg;

  localparam int HEADER_BEATS = 7;

  localparam logic [2:0] HDR_BEAT_OPCODE_PSN  = 3'd0;
  localparam logic [2:0] HDR_BEAT_DEST_QP     = 3'd1;
  localparam logic [2:0] HDR_BEAT_REMOTE_ADDR = 3'd2;
  localparam logic [2:0] HDR_BEAT_FRAG_OFF    = 3'd3;
  localparam logic [2:0] HDR_BEAT_LENGTH      = 3'd4;
  localparam logic [2:0] HDR_BEAT_PKEY        = 3'd5;
  localparam logic [2:0] HDR_BEAT_SL          = 3'd6;

  localparam logic [23:0] HDR_MARKER = 24'hABABAB;

  localparam int OPCODE_W = 8;
  localparam int PSN_W    = 24;
  localparam int QP_W     = 24;
  localparam int ADDR_W   = 32;
  localparam int LEN_W    = 32;
  localparam int FRAG_W   = 16;
  localparam int PKEY_W   = 16;
  localparam int SL_W     = 8;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_META = 2'd1,
    S_DATA = 2'd2,
    S_DROP = 2'd3
  } rdma_state_t;

endpackage

`default_nettype wire

// File: rtl/axis_keep_count.sv
// ============================================================================
// axis_keep_count: number of valid bytes in a 4-bit tkeep. Rev 1.0
// ============================================================================
`default_nettype none

module axis_keep_count (
  input  logic [3:0] keep,
  output logic [2:0] count
);

  always_comb begin
    count = 3'(keep[0]) + 3'(keep[1]) + 3'(keep[2]) + 3'(keep[3]);
  end

endmodule

`default_nettype wire

// File: rtl/rx_header_extractor.sv
// ============================================================================
// rx_header_extractor: strips the RDMA header, decodes it, forwards payload. Rev 1.0
// ============================================================================
`default_nettype none

module rx_header_extractor #(
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int C_AXIS_TKEEP_WIDTH = 4,
  parameter int HEADER_BEATS       = 7,
  parameter bit CHECK_MARKER       = 1'b1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          hdr_valid,
  input  logic                          hdr_ready,
  output logic [7:0]                    hdr_opcode,
  output logic [23:0]                   hdr_psn,
  output logic [23:0]                   hdr_dest_qp,
  output logic [31:0]                   hdr_remote_addr,
  output logic [31:0]                   hdr_length,
  output logic [15:0]                   hdr_fragment_offset,
  output logic [15:0]                   hdr_partition_key,
  output logic [7:0]                    hdr_service_level,
  output logic                          rx_busy,
  output logic                          rx_done,
  output logic                          hdr_error,
  output logic                          length_error
);

  import rdma_hdr_pkg::*;

  rdma_state_t state_q, state_d;
  logic [2:0]  beat_cnt;
  logic [31:0] byte_cnt;
  logic [31:0] byte_total;
  logic [2:0]  keep_cnt;
  logic        last_hdr_beat;
  logic        marker_bad;

  axis_keep_count u_keep_count (
    .keep  (s_axis_tkeep),
    .count (keep_cnt)
  );

  assign last_hdr_beat = (beat_cnt == 3'(HEADER_BEATS - 1));
  assign marker_bad    = CHECK_MARKER && (s_axis_tdata[31:8] != HDR_MARKER);
  assign byte_total    = byte_cnt + {29'd0, keep_cnt};

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tkeep = s_axis_tkeep;
  assign m_axis_tlast = s_axis_tlast;
  assign rx_busy      = !((state_q == S_HDR) && (beat_cnt == 3'd0));

  always_comb begin
    state_d       = state_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    hdr_valid     = 1'b0;
    case (state_q)
      S_HDR: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && !s_axis_tlast && last_hdr_beat)
          state_d = marker_bad ? S_DROP : S_META;
      end
      S_META: begin
        hdr_valid = 1'b1;
        if (hdr_ready) state_d = S_DATA;
      end
      S_DATA: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_d = S_HDR;
      end
      S_DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
    // The state register may still hold S_DATA/S_META until the reset edge.
    if (areset) begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      hdr_valid     = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q             <= S_HDR;
      beat_cnt            <= 3'd0;
      byte_cnt            <= 32'd0;
      hdr_opcode          <= '0;
      hdr_psn             <= '0;
      hdr_dest_qp         <= '0;
      hdr_remote_addr     <= '0;
      hdr_length          <= '0;
      hdr_fragment_offset <= '0;
      hdr_partition_key   <= '0;
      hdr_service_level   <= '0;
      rx_done             <= 1'b0;
      hdr_error           <= 1'b0;
      length_error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_done      <= 1'b0;
      hdr_error    <= 1'b0;
      length_error <= 1'b0;
      case (state_q)
        S_HDR: begin
          if (s_axis_tvalid) begin
            case (beat_cnt)
              HDR_BEAT_OPCODE_PSN: begin
                hdr_opcode <= s_axis_tdata[7:0];
                hdr_psn    <= s_axis_tdata[31:8];
              end
              HDR_BEAT_DEST_QP:     hdr_dest_qp         <= s_axis_tdata[23:0];
              HDR_BEAT_REMOTE_ADDR: hdr_remote_addr     <= s_axis_tdata;
              HDR_BEAT_FRAG_OFF:    hdr_fragment_offset <= s_axis_tdata[15:0];
              HDR_BEAT_LENGTH:      hdr_length          <= s_axis_tdata;
              HDR_BEAT_PKEY:        hdr_partition_key   <= s_axis_tdata[15:0];
              HDR_BEAT_SL:          hdr_service_level   <= s_axis_tdata[7:0];
              default: ;
            endcase
            if (s_axis_tlast) begin
              hdr_error <= 1'b1;
              beat_cnt  <= 3'd0;
            end else if (last_hdr_beat) begin
              beat_cnt <= 3'd0;
              if (marker_bad) hdr_error <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 3'd1;
            end
          end
        end
        S_META: begin
          if (hdr_ready) byte_cnt <= 32'd0;
        end
        S_DATA: begin
          if (s_axis_tvalid && m_axis_tready) begin
            byte_cnt <= byte_total;
            if (s_axis_tlast) begin
              if (byte_total == hdr_length) rx_done <= 1'b1;
              else                          length_error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rx_header_extractor.sv
// ============================================================================
// tb_rx_header_extractor: directed table plus randomized packets vs a queue model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_rx_header_extractor;

  localparam logic [23:0] MARK   = 24'hABABAB;
  localparam logic [2:0]  K_GOOD = 3'b100;  // {rx_done, hdr_error, length_error}
  localparam logic [2:0]  K_HDR  = 3'b010;
  localparam logic [2:0]  K_LEN  = 3'b001;

  typedef struct {
    logic [7:0]  op;
    logic [23:0] psn;
    logic [23:0] qp;
    logic [31:0] addr;
    logic [15:0] frag;
    logic [31:0] len;
    logic [15:0] pkey;
    logic [31:0] w6;
    int          npay;
    logic [31:0] keeps;    // nibble i = tkeep of payload beat i
    int          runt_at;  // header beat carrying tlast, -1 for none
    logic [2:0]  kind;
  } vec_t;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] s_axis_tdata = '0;
  logic [3:0]  s_axis_tkeep = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tlast;
  logic        m_axis_tready;
  logic        hdr_valid, hdr_ready;
  logic [7:0]  hdr_opcode, hdr_service_level;
  logic [23:0] hdr_psn, hdr_dest_qp;
  logic [31:0] hdr_remote_addr, hdr_length;
  logic [15:0] hdr_fragment_offset, hdr_partition_key;
  logic        rx_busy, rx_done, hdr_error, length_error;

  int total = 0;
  int bad = 0;
  bit stall_mode = 1'b0;
  logic [2:0]   outq[$];
  logic [159:0] hdrq[$];
  logic [36:0]  payq[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  rx_header_extractor dut (
    .aclk(clk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_opcode(hdr_opcode), .hdr_psn(hdr_psn), .hdr_dest_qp(hdr_dest_qp),
    .hdr_remote_addr(hdr_remote_addr), .hdr_length(hdr_length),
    .hdr_fragment_offset(hdr_fragment_offset), .hdr_partition_key(hdr_partition_key),
    .hdr_service_level(hdr_service_level),
    .rx_busy(rx_busy), .rx_done(rx_done), .hdr_error(hdr_error), .length_error(length_error)
  );

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [159:0] fields_now();
    return {hdr_opcode, hdr_psn, hdr_dest_qp, hdr_remote_addr, hdr_length,
            hdr_fragment_offset, hdr_partition_key, hdr_service_level};
  endfunction

  function automatic logic [159:0] fields_of(input vec_t p);
    return {p.op, p.psn, p.qp, p.addr, p.len, p.frag, p.pkey, p.w6[7:0]};
  endfunction

  function automatic logic [31:0] hdr_word(input vec_t p, input int i);
    case (i)
      0:       return {p.psn, p.op};
      1:       return {8'h00, p.qp};
      2:       return p.addr;
      3:       return {16'h0000, p.frag};
      4:       return p.len;
      5:       return {16'h0000, p.pkey};
      default: return p.w6;
    endcase
  endfunction

  // Reference model: outcome of a packet from its bytes, marker and runt position.
  function automatic vec_t rand_pkt();
    vec_t p;
    int   bytes = 0;
    p.op   = 8'($urandom);
    p.psn  = 24'($urandom);
    p.qp   = 24'($urandom);
    p.addr = $urandom;
    p.frag = 16'($urandom);
    p.pkey = 16'($urandom);
    p.w6   = ($urandom_range(7, 0) == 0) ? $urandom : {MARK, 8'($urandom)};
    p.npay = int'($urandom_range(6, 1));
    p.keeps = '0;
    for (int i = 0; i < p.npay; i++) begin
      p.keeps[4*i +: 4] = ($urandom_range(1, 0) == 1) ? 4'hF : 4'($urandom_range(15, 1));
      bytes += $countones(p.keeps[4*i +: 4]);
    end
    p.len = ($urandom_range(3, 0) == 0) ? 32'(bytes + int'($urandom_range(5, 1))) : 32'(bytes);
    if ($urandom_range(9, 0) == 0) p.runt_at = int'($urandom_range(6, 0));
    else                           p.runt_at = -1;
    if (p.runt_at >= 0 || p.w6[31:8] != MARK) p.kind = K_HDR;
    else if (32'(bytes) == p.len)             p.kind = K_GOOD;
    else                                      p.kind = K_LEN;
    return p;
  endfunction

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input bit stall);
    int waited = 0;
    if (stall) begin
      while ($urandom_range(1, 0) == 1) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready) begin
      waited++;
      if (waited > 2000) begin
        bad++;
        $display("FAIL beat_timeout: tready low for %0d cycles, expected a transfer", waited);
        $fatal(1, "input stream stuck");
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_packet(input vec_t p, input bit stall);
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    outq.push_back(p.kind);
    if (p.runt_at >= 0) begin
      for (int i = 0; i <= p.runt_at; i++) drive_beat(hdr_word(p, i), 4'hF, (i == p.runt_at), stall);
    end else begin
      if (p.kind != K_HDR) hdrq.push_back(fields_of(p));
      for (int i = 0; i < 7; i++) drive_beat(hdr_word(p, i), 4'hF, 1'b0, stall);
      for (int i = 0; i < p.npay; i++) begin
        d = $urandom;
        k = p.keeps[4*i +: 4];
        l = (i == p.npay - 1);
        if (p.kind != K_HDR) payq.push_back({d, k, l});
        drive_beat(d, k, l, stall);
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic settle_check();
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("outcome_drained", 160'(outq.size()), 160'(0));
    chk("header_drained", 160'(hdrq.size()), 160'(0));
    chk("payload_drained", 160'(payq.size()), 160'(0));
    chk("idle_busy", 160'(rx_busy), 160'(0));
    @(posedge clk); #1;
  endtask

  // Ready-side stimulus
  initial begin
    m_axis_tready = 1'b1;
    hdr_ready     = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_axis_tready = stall_mode ? 1'($urandom_range(1, 0)) : 1'b1;
      hdr_ready     = stall_mode ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Scoreboard monitor, sampled on the falling edge
  initial begin
    bit           prev_hv = 1'b0;
    bit           exp_end_pulse = 1'b0;
    logic [159:0] prev_f = '0;
    logic [2:0]   pulses;
    forever begin
      @(negedge clk);
      if (areset) begin
        prev_hv = 1'b0;
        exp_end_pulse = 1'b0;
      end else begin
        pulses = {rx_done, hdr_error, length_error};
        if (exp_end_pulse) chk("end_pulse_timing", 160'(rx_done | length_error), 160'(1));
        exp_end_pulse = 1'b0;
        if (pulses != 3'b000) begin
          if (outq.size() == 0) chk("unexpected_pulse", 160'(pulses), 160'(0));
          else                  chk("pulse_kind", 160'(pulses), 160'(outq.pop_front()));
        end
        if (prev_hv && hdr_valid) chk("hdr_stable", fields_now(), prev_f);
        if (hdr_valid && hdr_ready) begin
          if (hdrq.size() == 0) chk("unexpected_hdr", 160'(hdr_valid), 160'(0));
          else                  chk("hdr_fields", fields_now(), hdrq.pop_front());
        end
        prev_hv = hdr_valid && !hdr_ready;
        prev_f  = fields_now();
        if (m_axis_tvalid && m_axis_tready) begin
          if (payq.size() == 0) chk("unexpected_payload", 160'(m_axis_tvalid), 160'(0));
          else chk("payload_beat", 160'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 160'(payq.pop_front()));
          if (m_axis_tlast) exp_end_pulse = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t p;
    logic [31:0] d;

    tbl[0] = '{8'h0A, 24'h000123, 24'h000045, 32'h1000_0000, 16'h0004, 32'd12, 16'hFFFF,
               32'hABABAB03, 3, 32'h0000_0FFF, -1, K_GOOD};
    tbl[1] = '{8'h0A, 24'h000124, 24'h000045, 32'h1000_0010, 16'h0004, 32'd16, 16'hFFFF,
               32'h12345603, 4, 32'h0000_FFFF, -1, K_HDR};
    tbl[2] = '{8'h11, 24'hABCDEF, 24'h123456, 32'hDEAD_BEEF, 16'h0100, 32'd7, 16'h8001,
               32'hABABAB0F, 2, 32'h0000_007F, -1, K_GOOD};
    tbl[3] = '{8'h0C, 24'h000200, 24'h000046, 32'h2000_0040, 16'h0000, 32'd10, 16'h7FFF,
               32'hABABAB01, 6, 32'h0011_11FF, -1, K_LEN};
    tbl[4] = '{8'h0C, 24'h000201, 24'h000046, 32'h2000_0080, 16'h0002, 32'd10, 16'h7FFF,
               32'hABABAB01, 3, 32'h0000_03FF, -1, K_GOOD};
    tbl[5] = '{8'h33, 24'h000300, 24'h000047, 32'h3000_0000, 16'h0000, 32'd4, 16'h0001,
               32'hABABAB02, 1, 32'h0000_000F, 3, K_HDR};
    tbl[6] = '{8'h0A, 24'h000301, 24'h000048, 32'h3000_1000, 16'h0008, 32'd4, 16'h0002,
               32'hABABABFF, 1, 32'h0000_000F, -1, K_GOOD};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tready", 160'(s_axis_tready), 160'(0));
    @(posedge clk); #1;
    areset = 1'b0;
    @(negedge clk);
    chk("reset_hdr_valid", 160'(hdr_valid), 160'(0));
    chk("reset_m_tvalid", 160'(m_axis_tvalid), 160'(0));
    chk("reset_pulses", 160'({rx_done, hdr_error, length_error}), 160'(0));
    chk("reset_busy", 160'(rx_busy), 160'(0));
    chk("reset_fields", fields_now(), 160'(0));
    chk("idle_tready", 160'(s_axis_tready), 160'(1));
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      send_packet(tbl[i], 1'b0);
      settle_check();
    end

    // Reset in the middle of a payload
    p = tbl[0];
    hdrq.push_back(fields_of(p));
    for (int i = 0; i < 7; i++) drive_beat(hdr_word(p, i), 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      payq.push_back({d, 4'hF, 1'b0});
      drive_beat(d, 4'hF, 1'b0, 1'b0);
    end
    areset = 1'b1;
    @(negedge clk);
    chk("midrst_tready", 160'(s_axis_tready), 160'(0));
    chk("midrst_m_tvalid", 160'(m_axis_tvalid), 160'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_fields", fields_now(), 160'(0));
    chk("midrst_pulses", 160'({rx_done, hdr_error, length_error, hdr_valid}), 160'(0));
    chk("midrst_busy", 160'(rx_busy), 160'(0));
    hdrq.delete();
    payq.delete();
    outq.delete();
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    areset = 1'b0;
    send_packet(tbl[2], 1'b0);
    settle_check();

    stall_mode = 1'b1;
    for (int n = 0; n < 100; n++) send_packet(rand_pkt(), 1'b1);
    stall_mode = 1'b0;
    settle_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
